sha3_hash_packer: RTL

- Parametrised successor to the 4x64 SHA3 hash collector.
- Gathers WORDS input words of DIN_W bits into one hash, then serialises the hash into a downstream output FIFO.
- Has a two-slot ping-pong buffer, so the next hash is collected while the previous one drains.
- Sits between the SHA3 core output and the result FIFO in the miner datapath.

---
 rtl/sha3_hash_packer_pkg.sv | 10 +
 rtl/sha3_hash_packer_if.sv | 24 ++
 rtl/sha3_hash_packer_hash_slot.sv | 28 ++
 rtl/sha3_hash_packer.sv | 76 +++++++
 4 files changed

// File: rtl/sha3_hash_packer_pkg.sv
// sha3_fifo_pkg: shared slot state encoding and counter-width helper for sha3_hash_packer.
package sha3_fifo_pkg;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} slot_state_t;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sha3_hash_packer_if.sv
// sha3_hash_packer_if: input word bus, output FIFO bus and status of sha3_hash_packer.
// SHA3_PACKER_CNT_EN adds the hash_count signal.
interface sha3_hash_packer_if #(parameter int DIN_W = 64);
    logic             we_in;
    logic [DIN_W-1:0] din;
    logic             ready;
    logic             fifo_full;
    logic             fifo_we;
    logic [DIN_W-1:0] dout;
    logic             fifo_last;
    logic             busy;
`ifdef SHA3_PACKER_CNT_EN
    logic [31:0]      hash_count;
    modport slave (input we_in, din, fifo_full,
                   output ready, fifo_we, dout, fifo_last, busy, hash_count);
    modport master (output we_in, din, fifo_full,
                    input ready, fifo_we, dout, fifo_last, busy, hash_count);
`else
    modport slave (input we_in, din, fifo_full,
                   output ready, fifo_we, dout, fifo_last, busy);
    modport master (output we_in, din, fifo_full,
                    input ready, fifo_we, dout, fifo_last, busy);
`endif
endinterface

// File: rtl/sha3_hash_packer_hash_slot.sv
// hash_slot: one ping-pong buffer slot holding a hash's lanes and its fill/drain state.
module hash_slot
    import sha3_fifo_pkg::*;
#(
    parameter int DIN_W = 64,
    parameter int WORDS = 4,
    localparam int CW   = cnt_w(WORDS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic                             last,
    input  logic [CW-1:0]                    lane,
    input  logic [DIN_W-1:0]                 din,
    input  logic                             drain,
    input  logic                             done,
    output slot_state_t                      state,
    output logic [(1<<CW)-1:0][DIN_W-1:0]    lanes
);

    always_ff @(posedge clk)
        if (load) lanes[lane] <= din;

    always_ff @(posedge clk)
        if (rst) state <= EMPTY;
        else     state <= done ? EMPTY : load ? (last ? FULL : FILLING) : drain ? DRAINING : state;

endmodule

// File: rtl/sha3_hash_packer.sv
// sha3_hash_packer: collects WORDS input words per hash into a ping-pong buffer and drains them to a FIFO.
// Optional SHA3_PACKER_CNT_EN adds a 32-bit count of drained hashes.
module sha3_hash_packer
    import sha3_fifo_pkg::*;
#(
    parameter int DIN_W       = 64,
    parameter int WORDS       = 4,
    parameter int REVERSE_OUT = 1
) (
    input logic               clk,
    input logic               rst,
    sha3_hash_packer_if.slave bus
);

    localparam int CW = cnt_w(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    logic                          wp, rp;
    logic [CW-1:0]                 in_cnt, out_cnt, idx;
    logic                          acc, fill_last, drn, out_last;
    slot_state_t                   st [2];
    logic [(1<<CW)-1:0][DIN_W-1:0] lanes [2];

    for (genvar i = 0; i < 2; i++) begin : g_slot
        hash_slot #(.DIN_W(DIN_W), .WORDS(WORDS)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (acc && wp == 1'(i)),
            .last  (fill_last),
            .lane  (in_cnt),
            .din   (bus.din),
            .drain (drn && rp == 1'(i)),
            .done  (out_last && rp == 1'(i)),
            .state (st[i]),
            .lanes (lanes[i])
        );
    end

    always_comb begin
        bus.ready     = st[wp] == EMPTY || st[wp] == FILLING;
        acc           = bus.we_in && bus.ready;
        fill_last     = acc && in_cnt == LAST;
        drn           = (st[rp] == FULL || st[rp] == DRAINING) && !bus.fifo_full;
        out_last      = drn && out_cnt == LAST;
        idx           = (REVERSE_OUT != 0) ? LAST - out_cnt : out_cnt;
        bus.fifo_we   = drn;
        bus.dout      = drn ? lanes[rp][idx] : '0;
        bus.fifo_last = out_last;
        bus.busy      = st[0] != EMPTY || st[1] != EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= 1'b0;
            rp      <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (acc) begin
                in_cnt <= fill_last ? '0 : in_cnt + 1'b1;
                wp     <= wp ^ fill_last;
            end
            if (drn) begin
                out_cnt <= out_last ? '0 : out_cnt + 1'b1;
                rp      <= rp ^ out_last;
            end
        end
    end

`ifdef SHA3_PACKER_CNT_EN
    always_ff @(posedge clk)
        if (rst)           bus.hash_count <= '0;
        else if (out_last) bus.hash_count <= bus.hash_count + 1'b1;
`endif

endmodule
